// File: rtl/writeback_stage_if.sv
// Status/icode constants, FSM state type and the W-stage bus interface shared by
// writeback_stage and whatever drives it (memory stage, hazard control, register file).
package writeback_pkg;
  localparam logic [2:0] STAT_BUBBLE = 3'd0;
  localparam logic [2:0] STAT_OK     = 3'd1;
  localparam logic [2:0] STAT_HLT    = 3'd2;
  localparam logic [2:0] STAT_ADR    = 3'd3;
  localparam logic [2:0] STAT_INS    = 3'd4;
  localparam logic [2:0] STAT_RESET  = 3'd5;
  localparam logic [3:0] INOP        = 4'h1;

  typedef enum logic [1:0] {FSM_RUN, FSM_HALT, FSM_ERR} fsm_t;
endpackage

interface writeback_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 4
);
  logic              stall_i;
  logic              bubble_i;
  logic [2:0]        m_stat_i;
  logic [3:0]        m_icode_i;
  logic [DATA_W-1:0] m_valE_i;
  logic [DATA_W-1:0] m_valM_i;
  logic [REG_AW-1:0] m_dstE_i;
  logic [REG_AW-1:0] m_dstM_i;

  logic              we_e_o;
  logic [REG_AW-1:0] waddr_e_o;
  logic [DATA_W-1:0] wdata_e_o;
  logic              we_m_o;
  logic [REG_AW-1:0] waddr_m_o;
  logic [DATA_W-1:0] wdata_m_o;
  logic [REG_AW-1:0] W_dstE_o;
  logic [REG_AW-1:0] W_dstM_o;
  logic [DATA_W-1:0] W_valE_o;
  logic [DATA_W-1:0] W_valM_o;
  logic [3:0]        W_icode_o;
  logic [2:0]        W_stat_o;
  logic [2:0]        cpu_stat_o;
  logic              halted_o;

  modport master (
    output stall_i, bubble_i, m_stat_i, m_icode_i, m_valE_i, m_valM_i, m_dstE_i, m_dstM_i,
    input  we_e_o, waddr_e_o, wdata_e_o, we_m_o, waddr_m_o, wdata_m_o,
           W_dstE_o, W_dstM_o, W_valE_o, W_valM_o, W_icode_o, W_stat_o, cpu_stat_o, halted_o
  );

  modport slave (
    input  stall_i, bubble_i, m_stat_i, m_icode_i, m_valE_i, m_valM_i, m_dstE_i, m_dstM_i,
    output we_e_o, waddr_e_o, wdata_e_o, we_m_o, waddr_m_o, wdata_m_o,
           W_dstE_o, W_dstM_o, W_valE_o, W_valM_o, W_icode_o, W_stat_o, cpu_stat_o, halted_o
  );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 W stage: pipeline register, register-file write ports and sticky status FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
  import writeback_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  writeback_stage_if.slave wb
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retired_o
`endif
);

  localparam logic [REG_AW-1:0] NO_REG = {REG_AW{1'b1}};

  logic [2:0]        w_stat;
  logic [3:0]        w_icode;
  logic [DATA_W-1:0] w_val_e;
  logic [DATA_W-1:0] w_val_m;
  logic [REG_AW-1:0] w_dst_e;
  logic [REG_AW-1:0] w_dst_m;

  fsm_t       state;
  logic [2:0] cpu_stat;
  logic       halted;
  logic       commit;
  logic       dst_clash;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_stat  <= STAT_RESET;
      w_icode <= INOP;
      w_val_e <= '0;
      w_val_m <= '0;
      w_dst_e <= NO_REG;
      w_dst_m <= NO_REG;
    end else if (wb.stall_i) begin
      w_stat  <= w_stat;
    end else if (wb.bubble_i) begin
      w_stat  <= STAT_BUBBLE;
      w_icode <= INOP;
      w_val_e <= '0;
      w_val_m <= '0;
      w_dst_e <= NO_REG;
      w_dst_m <= NO_REG;
    end else begin
      w_stat  <= wb.m_stat_i;
      w_icode <= wb.m_icode_i;
      w_val_e <= wb.m_valE_i;
      w_val_m <= wb.m_valM_i;
      w_dst_e <= wb.m_dstE_i;
      w_dst_m <= wb.m_dstM_i;
    end
  end

  // Status FSM: halt and fault are sticky; the faulting code is captured on entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= FSM_RUN;
      cpu_stat <= STAT_OK;
      halted   <= 1'b0;
    end else if (state == FSM_RUN) begin
      if (w_stat == STAT_HLT) begin
        state    <= FSM_HALT;
        cpu_stat <= STAT_HLT;
        halted   <= 1'b1;
      end else if (w_stat == STAT_ADR || w_stat == STAT_INS) begin
        state    <= FSM_ERR;
        cpu_stat <= w_stat;
        halted   <= 1'b1;
      end
    end
  end

  // The halting instruction commits; a faulting one, or anything after leaving RUN, does not.
  assign commit    = (w_stat == STAT_OK || w_stat == STAT_HLT) && state == FSM_RUN;
  assign dst_clash = (w_dst_e == w_dst_m) && (w_dst_m != NO_REG);

  assign wb.we_e_o    = commit && (w_dst_e != NO_REG) && !dst_clash;
  assign wb.waddr_e_o = w_dst_e;
  assign wb.wdata_e_o = w_val_e;
  assign wb.we_m_o    = commit && (w_dst_m != NO_REG);
  assign wb.waddr_m_o = w_dst_m;
  assign wb.wdata_m_o = w_val_m;

  assign wb.W_dstE_o   = w_dst_e;
  assign wb.W_dstM_o   = w_dst_m;
  assign wb.W_valE_o   = w_val_e;
  assign wb.W_valM_o   = w_val_m;
  assign wb.W_icode_o  = w_icode;
  assign wb.W_stat_o   = w_stat;
  assign wb.cpu_stat_o = cpu_stat;
  assign wb.halted_o   = halted;

`ifdef WB_RETIRE_CNT_EN
  // A stalled instruction stays in W, so it is counted only on the edge it leaves.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retired_o <= '0;
    end else if (commit && !wb.stall_i && w_icode != INOP) begin
      retired_o <= retired_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected outputs,
// a negedge monitor pops and compares them in the cycle they become visible.
module tb_writeback_stage;

  localparam logic [2:0] S_BUB = 3'd0, S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3,
                         S_INS = 3'd4, S_RST = 3'd5;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_IRMOV = 4'h3, I_MRMOV = 4'h5,
                         I_OPQ = 4'h6, I_POP = 4'hb;
  localparam logic [3:0] RNONE = 4'hf;

  typedef struct {
    int          cyc;
    logic        we_e;
    logic [3:0]  wa_e;
    logic [63:0] wd_e;
    logic        we_m;
    logic [3:0]  wa_m;
    logic [63:0] wd_m;
    logic [3:0]  dste;
    logic        hlt;
    logic [2:0]  cst;
    logic [63:0] ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fails = 0;
  exp_t sb[$];

  writeback_stage_if #(.DATA_W(64), .REG_AW(4)) bus ();

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
  writeback_stage #(.DATA_W(64), .REG_AW(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb(bus.slave), .retired_o(retired)
  );
`else
  writeback_stage #(.DATA_W(64), .REG_AW(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb(bus.slave)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input logic st, input logic bu, input logic [2:0] s, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
    bus.stall_i   = st;
    bus.bubble_i  = bu;
    bus.m_stat_i  = s;
    bus.m_icode_i = ic;
    bus.m_valE_i  = ve;
    bus.m_valM_i  = vm;
    bus.m_dstE_i  = de;
    bus.m_dstM_i  = dm;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, S_BUB, I_NOP, 64'd0, 64'd0, RNONE, RNONE);
  endtask

  task automatic step(input logic st, input logic bu, input logic [2:0] s, input logic [3:0] ic,
                      input logic [63:0] ve, input logic [63:0] vm,
                      input logic [3:0] de, input logic [3:0] dm);
    @(posedge clk);
    #1;
    drive(st, bu, s, ic, ve, vm, de, dm);
  endtask

  // Expected outputs for the cycle after the next posedge.
  task automatic expect_next(input logic we_e, input logic [3:0] wa_e, input logic [63:0] wd_e,
                             input logic we_m, input logic [3:0] wa_m, input logic [63:0] wd_m,
                             input logic [3:0] dste, input logic hlt, input logic [2:0] cst,
                             input logic [63:0] ret);
    exp_t e;
    e.cyc = cyc + 1;
    e.we_e = we_e; e.wa_e = wa_e; e.wd_e = wd_e;
    e.we_m = we_m; e.wa_m = wa_m; e.wd_m = wd_m;
    e.dste = dste; e.hlt = hlt; e.cst = cst; e.ret = ret;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      check("sb_stale_entry", 64'(sb[0].cyc), 64'(cyc));
      void'(sb.pop_front());
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("we_e",     64'(bus.we_e_o),     64'(e.we_e));
      check("waddr_e",  64'(bus.waddr_e_o),  64'(e.wa_e));
      check("wdata_e",  bus.wdata_e_o,       e.wd_e);
      check("we_m",     64'(bus.we_m_o),     64'(e.we_m));
      check("waddr_m",  64'(bus.waddr_m_o),  64'(e.wa_m));
      check("wdata_m",  bus.wdata_m_o,       e.wd_m);
      check("W_dstE",   64'(bus.W_dstE_o),   64'(e.dste));
      check("halted",   64'(bus.halted_o),   64'(e.hlt));
      check("cpu_stat", 64'(bus.cpu_stat_o), 64'(e.cst));
`ifdef WB_RETIRE_CNT_EN
      check("retired",  retired,             e.ret);
`endif
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we_e"},     64'(bus.we_e_o),     64'd0);
    check({tag, "_we_m"},     64'(bus.we_m_o),     64'd0);
    check({tag, "_W_dstE"},   64'(bus.W_dstE_o),   64'(RNONE));
    check({tag, "_W_dstM"},   64'(bus.W_dstM_o),   64'(RNONE));
    check({tag, "_W_stat"},   64'(bus.W_stat_o),   64'(S_RST));
    check({tag, "_W_icode"},  64'(bus.W_icode_o),  64'(I_NOP));
    check({tag, "_W_valE"},   bus.W_valE_o,        64'd0);
    check({tag, "_cpu_stat"}, 64'(bus.cpu_stat_o), 64'(S_AOK));
    check({tag, "_halted"},   64'(bus.halted_o),   64'd0);
`ifdef WB_RETIRE_CNT_EN
    check({tag, "_retired"},  retired,             64'd0);
`endif
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state(tag);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    #12;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Retiring sequence: irmovq, popq %rsp, opq, two bubbles, mrmovq, irmovq.
    step(0, 0, S_AOK, I_IRMOV, 64'h10, 64'h0, 4'd3, RNONE);
    expect_next(1, 4'd3, 64'h10, 0, RNONE, 64'h0, 4'd3, 0, S_AOK, 64'd0);
    step(0, 0, S_AOK, I_POP, 64'h108, 64'hABCD, 4'd4, 4'd4);
    expect_next(0, 4'd4, 64'h108, 1, 4'd4, 64'hABCD, 4'd4, 0, S_AOK, 64'd1);
    step(0, 0, S_AOK, I_OPQ, 64'h5, 64'h0, 4'd2, RNONE);
    expect_next(1, 4'd2, 64'h5, 0, RNONE, 64'h0, 4'd2, 0, S_AOK, 64'd2);
    step(0, 1, S_AOK, I_OPQ, 64'h99, 64'h0, 4'd7, RNONE);
    expect_next(0, RNONE, 64'h0, 0, RNONE, 64'h0, RNONE, 0, S_AOK, 64'd3);
    step(0, 1, S_AOK, I_OPQ, 64'h99, 64'h0, 4'd7, RNONE);
    expect_next(0, RNONE, 64'h0, 0, RNONE, 64'h0, RNONE, 0, S_AOK, 64'd3);
    step(0, 0, S_AOK, I_MRMOV, 64'h20, 64'h99, RNONE, 4'd6);
    expect_next(0, RNONE, 64'h20, 1, 4'd6, 64'h99, RNONE, 0, S_AOK, 64'd3);
    step(0, 0, S_AOK, I_IRMOV, 64'h7, 64'h0, 4'd1, RNONE);
    expect_next(1, 4'd1, 64'h7, 0, RNONE, 64'h0, 4'd1, 0, S_AOK, 64'd4);

    // Stall holds W (write re-asserted each cycle); stall beats bubble; bubble alone clears.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, S_AOK, I_OPQ, 64'h55, 64'h0, 4'd9, RNONE);
      expect_next(1, 4'd1, 64'h7, 0, RNONE, 64'h0, 4'd1, 0, S_AOK, 64'd4);
    end
    step(1, 1, S_AOK, I_OPQ, 64'h55, 64'h0, 4'd9, RNONE);
    expect_next(1, 4'd1, 64'h7, 0, RNONE, 64'h0, 4'd1, 0, S_AOK, 64'd4);
    step(0, 1, S_AOK, I_OPQ, 64'h55, 64'h0, 4'd9, RNONE);
    expect_next(0, RNONE, 64'h0, 0, RNONE, 64'h0, RNONE, 0, S_AOK, 64'd5);

    // Halt commits (no write), then the following opq must not write; state persists.
    step(0, 0, S_HLT, I_HALT, 64'h0, 64'h0, RNONE, RNONE);
    expect_next(0, RNONE, 64'h0, 0, RNONE, 64'h0, RNONE, 0, S_AOK, 64'd5);
    step(0, 0, S_AOK, I_OPQ, 64'h33, 64'h0, 4'd2, RNONE);
    expect_next(0, 4'd2, 64'h33, 0, RNONE, 64'h0, 4'd2, 1, S_HLT, 64'd6);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, S_AOK, I_OPQ, 64'h33, 64'h0, 4'd2, RNONE);
      expect_next(0, 4'd2, 64'h33, 0, RNONE, 64'h0, 4'd2, 1, S_HLT, 64'd6);
    end
    drain();
    mid_reset("rst_after_halt");

    // Address fault on mrmovq: no M write, ADR captured and sticky.
    step(0, 0, S_AOK, I_IRMOV, 64'h77, 64'h0, 4'd5, RNONE);
    expect_next(1, 4'd5, 64'h77, 0, RNONE, 64'h0, 4'd5, 0, S_AOK, 64'd0);
    step(0, 0, S_ADR, I_MRMOV, 64'h0, 64'h88, RNONE, 4'd5);
    expect_next(0, RNONE, 64'h0, 0, 4'd5, 64'h88, RNONE, 0, S_AOK, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, S_AOK, I_OPQ, 64'h1, 64'h0, 4'd2, RNONE);
      expect_next(0, 4'd2, 64'h1, 0, RNONE, 64'h0, 4'd2, 1, S_ADR, 64'd1);
    end
    drain();
    mid_reset("rst_after_adr");

    // Invalid-instruction fault captures INS.
    step(0, 0, S_INS, 4'hd, 64'h0, 64'h0, RNONE, RNONE);
    expect_next(0, RNONE, 64'h0, 0, RNONE, 64'h0, RNONE, 0, S_AOK, 64'd0);
    step(0, 0, S_AOK, I_OPQ, 64'h2, 64'h0, 4'd3, RNONE);
    expect_next(0, 4'd3, 64'h2, 0, RNONE, 64'h0, 4'd3, 1, S_INS, 64'd0);
    drain();
    mid_reset("rst_after_ins");

    // Reset while a write is active drops the write enable immediately.
    step(0, 0, S_AOK, I_IRMOV, 64'h10, 64'h0, 4'd3, RNONE);
    expect_next(1, 4'd3, 64'h10, 0, RNONE, 64'h0, 4'd3, 0, S_AOK, 64'd0);
    drain();
    @(posedge clk);
    #2;
    check("pre_reset_we_e", 64'(bus.we_e_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid_write");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Y86-64 W pipeline stage. Latches the memory-stage result bundle, applies stall/bubble control, and drives the register-file write ports (E and M).
- Provides W-stage forwarding values to decode.
- Holds the sticky processor-status FSM: run, halted, or faulted.
- Optionally counts retired instructions.

Parameters:
- DATA_W, 64, data width of valE/valM and the write data.
- REG_AW, 4, register-ID width; all-ones (4'hf) means "no register".

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- stall_i  in  1  hold the W pipeline register
- bubble_i  in  1  load a bubble into the W pipeline register
- m_stat_i  in  3  memory-stage status (`STAT_* codes)
- m_icode_i  in  4  memory-stage icode
- m_valE_i  in  DATA_W  ALU result
- m_valM_i  in  DATA_W  memory read data
- m_dstE_i  in  REG_AW  E destination
- m_dstM_i  in  REG_AW  M destination
- we_e_o  out  1  register-file write enable, E port
- waddr_e_o  out  REG_AW  E write address
- wdata_e_o  out  DATA_W  E write data
- we_m_o  out  1  register-file write enable, M port
- waddr_m_o  out  REG_AW  M write address
- wdata_m_o  out  DATA_W  M write data
- W_dstE_o, W_dstM_o  out  REG_AW  forwarding IDs (latched)
- W_valE_o, W_valM_o  out  DATA_W  forwarding data (latched)
- W_icode_o  out  4  latched icode
- W_stat_o  out  3  latched stat
- cpu_stat_o  out  3  architectural processor status
- halted_o  out  1  FSM is not in RUN

Behaviour:
- Pipeline register (W_*), posedge clk_i. Priority: reset > stall > bubble > load.
  - Reset (async, immediate): stat=`STAT_RESET, icode=`INOP, valE=valM=0, dstE=dstM=4'hf.
  - stall_i=1: all fields hold. If stall_i and bubble_i are both 1, stall wins.
  - bubble_i=1: stat=`STAT_BUBBLE, icode=`INOP, valE=valM=0, dstE=dstM=4'hf.
  - Otherwise: every field loads the corresponding m_* input.
- Commit condition (combinational from the W register): commit = (W_stat==`STAT_OK || W_stat==`STAT_HLT) && fsm==RUN.
- E port:
  - we_e_o = commit && W_dstE!=4'hf && !(W_dstE==W_dstM && W_dstM!=4'hf).
  - When both destinations name the same register, M wins and the E write is suppressed (popq %rsp semantics).
  - waddr_e_o=W_dstE, wdata_e_o=W_valE.
- M port: we_m_o = commit && W_dstM!=4'hf. waddr_m_o=W_dstM, wdata_m_o=W_valM.
- Write timing: writes occur in the same cycle the instruction sits in W. The register file samples them at the next posedge, so latency is 1 cycle from M→W capture to register update.
- Status FSM (states RUN, HALT, ERR; async reset to RUN):
  - RUN → HALT when W_stat==`STAT_HLT.
  - RUN → ERR when W_stat==`STAT_ADR or `STAT_INS.
  - HALT and ERR are sticky until reset. stall_i and bubble_i do not affect the FSM.
- FSM outputs:
  - cpu_stat_o is `STAT_OK in RUN and during any stat of RESET/BUBBLE/STALL.
  - cpu_stat_o is `STAT_HLT in HALT.
  - In ERR, cpu_stat_o holds the faulting code captured on entry.
  - halted_o = (fsm != RUN).
  - Reset values: cpu_stat_o=`STAT_OK, halted_o=0, all we_*=0.
- Once the FSM leaves RUN, no further register writes occur, even if new OK instructions enter W.
- The halting instruction itself commits (halt has no destinations, so no write occurs). The faulting instruction does not commit.
- Reset asserted mid-operation: pipeline register and FSM clear asynchronously, and we_* drop to 0 in the same cycle.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- When defined:
  - Adds output retired_o (64 bits), reset to 0.
  - Increments by 1 at each posedge where commit=1, the register is not stalled that cycle, and W_icode!=`INOP.
  - Wraps modulo 2^64.
- When undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- Reset then OK irmovq (dstE=3, valE=64'h10) loaded → next cycle: we_e_o=1, waddr_e_o=3, wdata_e_o=64'h10, we_m_o=0.
- popq %rsp: dstE=4, dstM=4, valE=64'h108, valM=64'hABCD → we_e_o=0, we_m_o=1, wdata_m_o=64'hABCD.
- HLT enters W, then an OK opq with dstE=2 follows → halted_o=1, cpu_stat_o=`STAT_HLT, we_e_o=0 for the opq. State persists 10 cycles.
- `STAT_ADR mrmovq with dstM=5 enters W → we_m_o=0 that cycle; cpu_stat_o=`STAT_ADR sticky; deassert/reassert rst_n_i → RUN with cpu_stat_o=`STAT_OK.
- stall_i=1 for 3 cycles with W holding dstE=1, valE=7 → W_* unchanged and write re-asserted each cycle. With stall_i=bubble_i=1, the stall wins; bubble_i alone → W_dstE=4'hf, we_*=0.
- WB_RETIRE_CNT_EN: 5 OK non-nop instructions plus 2 bubbles, then halt → retired_o=6. Assert rst_n_i low mid-sequence → retired_o=0 immediately.
